vga_sync_generator: RTL and testbench

- Produces VGA raster timing: horizontal and vertical pixel counters, hSync/vSync pulses and the vidOn qualifier.
- Drives the pixel painter's vidOn input and supplies x/y coordinates to the color source.
- Sits between the pixel clock domain and the painter. One clock, no CDC.
- Default timing is 640x480 at 60 Hz, using an 800x525 total raster.

---
 rtl/vga_sync_generator_if.sv | 20 ++
 rtl/vga_sync_generator.sv | 104 ++++++++++
 tb/tb_vga_sync_generator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_sync_generator_if.sv
// rtl/vga_sync_generator_if.sv - raster timing bundle from the sync generator to the painter
interface vga_sync_generator_if #(
  parameter int CNT_W = 10
);
  logic             hSync;
  logic             vSync;
  logic             vidOn;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             frameStart;
  logic             pixTick;

  modport master (
    output hSync, vSync, vidOn, x, y, frameStart, pixTick
  );

  modport slave (
    input hSync, vSync, vidOn, x, y, frameStart, pixTick
  );
endinterface

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA raster counters and sync/vidOn decode; optional clk/2 via VGA_SYNC_CLK_DIV_EN
module vga_sync_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_sync_generator_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             pix_tick;
  logic             h_sync_q;
  logic             v_sync_q;
  logic             vid_on_q;
  logic             frame_start_q;

`ifdef VGA_SYNC_CLK_DIV_EN
  logic toggle;

  // Divide-by-two pixel strobe: ticks on every second clk after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle <= 1'b0;
    end else begin
      toggle <= ~toggle;
    end
  end

  assign pix_tick = toggle;
`else
  assign pix_tick = 1'b1;
`endif

  // Next raster position; the line counter only moves on a horizontal wrap
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + ONE;
      end
    end else begin
      h_nxt = h_cnt + ONE;
    end
  end

  // Counters and outputs share one edge: outputs are decoded from the next position
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      vid_on_q      <= 1'b0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else if (pix_tick) begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      vid_on_q      <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      h_sync_q      <= ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      v_sync_q      <= ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      frame_start_q <= (h_nxt == '0) && (v_nxt == '0);
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign vga.x          = h_cnt;
  assign vga.y          = v_cnt;
  assign vga.vidOn      = vid_on_q;
  assign vga.hSync      = h_sync_q;
  assign vga.vSync      = v_sync_q;
  assign vga.frameStart = frame_start_q;
  assign vga.pixTick    = pix_tick;

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - randomized reset/run bench against a position-index raster model
module tb_vga_sync_generator;

`ifdef VGA_SYNC_CLK_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // Default 640x480 raster
  localparam int T0 = 800 * 525;
  // Small raster, active-high syncs: 8+2+3+2 = 15 by 4+1+2+1 = 8
  localparam int T1 = 15 * 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: linear position within the frame, divider phase, expected frameStart
  int p0, p1;
  bit phase;
  bit fs0_e, fs1_e;
  bit rst_edge;
  int cyc = 0;
  int hs0_run = 0;
  int vs1_run = 0;
  int last_fs1 = -1;

  vga_sync_generator_if #(.CNT_W(10)) bus0 ();
  vga_sync_generator_if #(.CNT_W(4))  bus1 ();

  vga_sync_generator dut0 (
    .clk   (clk),
    .reset (reset),
    .vga   (bus0)
  );

  vga_sync_generator #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b1), .CNT_W (4)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .vga   (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs derived straight from the raster rules for position p
  task automatic chk_inst(input string nm, input int p, input bit fs_e, input bit pol,
                          input int ha, input int hf, input int hs, input int ht,
                          input int va, input int vf, input int vs,
                          input logic [31:0] ox, input logic [31:0] oy, input logic ovid,
                          input logic ohs, input logic ovs, input logic ofs, input logic opt);
    int ex, ey;
    bit hin, vin;
    ex  = p % ht;
    ey  = p / ht;
    hin = (ex >= ha + hf) && (ex < ha + hf + hs);
    vin = (ey >= va + vf) && (ey < va + vf + vs);
    chk({nm, ".x"}, ox, ex);
    chk({nm, ".y"}, oy, ey);
    chk({nm, ".vidOn"}, {31'd0, ovid}, {31'd0, (ex < ha) && (ey < va)});
    chk({nm, ".hSync"}, {31'd0, ohs}, {31'd0, hin ? pol : ~pol});
    chk({nm, ".vSync"}, {31'd0, ovs}, {31'd0, vin ? pol : ~pol});
    chk({nm, ".frameStart"}, {31'd0, ofs}, {31'd0, fs_e});
    chk({nm, ".pixTick"}, {31'd0, opt}, {31'd0, (DIV == 1) ? 1'b1 : phase});
  endtask

  // One clk: advance the model with the reset level seen at the edge, then check away from the edge
  task automatic step();
    bit adv;
    @(posedge clk);
    rst_edge = reset;
    if (reset) begin
      p0 = T0 - 1;
      p1 = T1 - 1;
      phase = 1'b0;
      fs0_e = 1'b0;
      fs1_e = 1'b0;
    end else begin
      adv = (DIV == 1) ? 1'b1 : phase;
      if (DIV == 2) phase = ~phase;
      if (adv) begin
        p0 = (p0 + 1) % T0;
        p1 = (p1 + 1) % T1;
      end
      fs0_e = adv && (p0 == 0);
      fs1_e = adv && (p1 == 0);
    end
    #1;
    cyc++;
    chk_inst("d0", p0, fs0_e, 1'b0, 640, 16, 96, 800, 480, 10, 2,
             {22'd0, bus0.x}, {22'd0, bus0.y}, bus0.vidOn, bus0.hSync, bus0.vSync,
             bus0.frameStart, bus0.pixTick);
    chk_inst("d1", p1, fs1_e, 1'b1, 8, 2, 3, 15, 4, 1, 2,
             {28'd0, bus1.x}, {28'd0, bus1.y}, bus1.vidOn, bus1.hSync, bus1.vSync,
             bus1.frameStart, bus1.pixTick);
    // Sync pulse widths and frame period measured in clk
    if (rst_edge) begin
      hs0_run  = 0;
      vs1_run  = 0;
      last_fs1 = -1;
    end else begin
      if (bus0.hSync === 1'b0) hs0_run++;
      else if (hs0_run > 0) begin
        chk("d0.hsync_width", hs0_run, 96 * DIV);
        hs0_run = 0;
      end
      if (bus1.vSync === 1'b1) vs1_run++;
      else if (vs1_run > 0) begin
        chk("d1.vsync_width", vs1_run, 2 * 15 * DIV);
        vs1_run = 0;
      end
      if (bus1.frameStart === 1'b1) begin
        if (last_fs1 >= 0) chk("d1.frame_period", cyc - last_fs1, T1 * DIV);
        last_fs1 = cyc;
      end
    end
  endtask

  initial begin
    p0 = T0 - 1;
    p1 = T1 - 1;
    phase = 1'b0;

    // Reset held for three clocks
    reset = 1'b1;
    repeat (3) step();
    chk("rst.x", {22'd0, bus0.x}, 799);
    chk("rst.y", {22'd0, bus0.y}, 524);
    chk("rst.hSync_pol1", {31'd0, bus1.hSync}, 0);

    // First tick after release enters (0,0)
    reset = 1'b0;
    step();
    if (DIV == 2) step();
    chk("first.x", {22'd0, bus0.x}, 0);
    chk("first.y", {22'd0, bus0.y}, 0);
    chk("first.vidOn", {31'd0, bus0.vidOn}, 1);
    chk("first.frameStart", {31'd0, bus0.frameStart}, 1);
    step();
    chk("second.frameStart", {31'd0, bus0.frameStart}, 0);

    // Two full lines of the default raster, many small frames
    repeat (1700 * DIV) step();
    chk("line2.y", {22'd0, bus0.y}, 2);

    // Random run lengths broken by random mid-frame resets
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(20, 1500)) step();
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      chk("midrst.x", {22'd0, bus0.x}, 799);
      chk("midrst.y", {22'd0, bus0.y}, 524);
      reset = 1'b0;
    end
    repeat (400) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
